// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Stage indices follow the stall bit order {wb,mem,ex,id,if,pc}.
package pipeline_ctrl_pkg;

  localparam int STALL_WIDTH = 6;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_encoder.sv
// Priority encoder from per-stage stall requests to a stall mask.
// The deepest requesting stage wins and freezes everything upstream.
module stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic                   i_req_if,
  input  logic                   i_req_id,
  input  logic                   i_req_ex,
  input  logic                   i_req_mem,
  output logic [STALL_WIDTH-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    priority case (1'b1)
      i_req_mem: o_mask = 6'b011111;
      i_req_ex:  o_mask = 6'b001111;
      i_req_id:  o_mask = 6'b000111;
      i_req_if:  o_mask = 6'b000011;
      default:   o_mask = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: stall mapping, exception/ERET flush sequencing,
// redirect target and saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_req_if,
  input  logic                   stall_req_id,
  input  logic                   stall_req_ex,
  input  logic                   stall_req_mem,
  input  logic                   exc_req,
  input  logic                   eret_req,
  input  logic [ADDR_WIDTH-1:0]  cp0_epc,
  input  logic                   perf_clear,
  output logic [STALL_WIDTH-1:0] stall,
  output logic                   flush,
  output logic [ADDR_WIDTH-1:0]  flush_pc,
  output logic                   exc_pending,
  output logic [31:0]            stall_cycles
);

  localparam logic [31:0] CNT_MAX = 32'hFFFFFFFF;

  ctrl_state_t             r_state;
  ctrl_state_t             w_state_nx;
  logic [ADDR_WIDTH-1:0]   r_target;
  logic [ADDR_WIDTH-1:0]   w_req_pc;
  logic                    w_capture;
  logic [STALL_WIDTH-1:0]  w_enc_mask;
  logic [31:0]             r_stall_cycles;

  stall_encoder u_enc (
    .i_req_if  (stall_req_if),
    .i_req_id  (stall_req_id),
    .i_req_ex  (stall_req_ex),
    .i_req_mem (stall_req_mem),
    .o_mask    (w_enc_mask)
  );

  assign w_req_pc = exc_req ? EXC_VECTOR : cp0_epc;

  always_comb begin
    w_state_nx  = r_state;
    w_capture   = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    stall       = '0;
    exc_pending = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (exc_req || eret_req) begin
          if (stall_req_mem) begin
            w_capture  = 1'b1;
            w_state_nx = PENDING;
            stall      = w_enc_mask;
          end else begin
            flush    = 1'b1;
            flush_pc = w_req_pc;
          end
        end else begin
          stall = w_enc_mask;
        end
      end
      PENDING: begin
        exc_pending = 1'b1;
        if (stall_req_mem) begin
          stall = 6'b011111;
        end else begin
          flush      = 1'b1;
          flush_pc   = r_target;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_target <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_capture) r_target <= w_req_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (perf_clear) begin
      r_stall_cycles <= '0;
    end else if (stall[STG_PC] && !flush && r_stall_cycles != CNT_MAX) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a behavioural model.
// Directed scenarios first, then a random request stream.
module tb_pipeline_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        exc_req, eret_req, perf_clear;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        exc_pending;
  logic [31:0] stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  bit          m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .cp0_epc       (cp0_epc),
    .perf_clear    (perf_clear),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .exc_pending   (exc_pending),
    .stall_cycles  (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic step(input bit sif, input bit sid, input bit sex,
                      input bit smem, input bit exc, input bit eret,
                      input logic [31:0] epc, input bit pclr);
    int          lvl;
    bit          e_flush;
    logic [31:0] e_pc;
    logic [5:0]  e_stall;
    bit          nx_pend;
    stall_req_if  = sif;
    stall_req_id  = sid;
    stall_req_ex  = sex;
    stall_req_mem = smem;
    exc_req       = exc;
    eret_req      = eret;
    cp0_epc       = epc;
    perf_clear    = pclr;
    #2;
    lvl = 0;
    if (sif)  lvl = 1;
    if (sid)  lvl = 2;
    if (sex)  lvl = 3;
    if (smem) lvl = 4;
    e_flush = 0;
    e_pc    = 32'h0;
    e_stall = 6'((1 << (lvl + 1)) - 1);
    if (lvl == 0) e_stall = 6'h0;
    nx_pend = m_pend;
    if (m_pend) begin
      e_stall = 6'h1F;
      if (!smem) begin
        e_flush = 1;
        e_pc    = m_tgt;
        nx_pend = 0;
      end
    end else if (exc || eret) begin
      if (smem) begin
        nx_pend = 1;
        m_tgt   = exc ? VEC : epc;
      end else begin
        e_flush = 1;
        e_pc    = exc ? VEC : epc;
      end
    end
    if (e_flush) e_stall = 6'h0;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    if (e_flush) chk("flush_pc", flush_pc, e_pc);
    chk("exc_pending", 32'(exc_pending), 32'(m_pend));
    chk("stall_cycles", stall_cycles, m_cnt);
    if (pclr) m_cnt = 32'h0;
    else if (e_stall[0] && !e_flush && m_cnt != 32'hFFFFFFFF)
      m_cnt = m_cnt + 1;
    m_pend = nx_pend;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    rst = 1'b1;
    {stall_req_if, stall_req_id, stall_req_ex, stall_req_mem} = '0;
    {exc_req, eret_req, perf_clear} = '0;
    cp0_epc = '0;
    m_pend = 0;
    m_tgt  = '0;
    m_cnt  = '0;
    #12;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_pc", flush_pc, 32'h0);
    chk("rst_pend", 32'(exc_pending), 32'h0);
    chk("rst_cnt", stall_cycles, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step(0, 1, 0, 0, 0, 0, 32'h0, 0);
    idle(1);
    step(1, 0, 1, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 1, 1, 0, 32'h80001000, 0);
    step(0, 0, 0, 1, 0, 1, 32'h80001000, 0);
    step(0, 0, 0, 1, 0, 0, 32'h80001000, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h80000400, 0);
    step(0, 0, 0, 1, 0, 1, 32'h80000800, 0);
    step(0, 0, 1, 0, 1, 0, 32'h0, 0);
    idle(1);

    force dut.r_stall_cycles = 32'hFFFFFFFE;
    #1;
    release dut.r_stall_cycles;
    m_cnt = 32'hFFFFFFFE;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 0, 0, 32'h0, 1);
    idle(1);

    step(0, 0, 0, 1, 1, 0, 32'h0, 0);
    stall_req_mem = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_pend", 32'(exc_pending), 32'h0);
    chk("rst_mid_cnt", stall_cycles, 32'h0);
    m_pend = 0;
    m_cnt  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 400; i++) begin
      bit smem;
      smem = ($urandom_range(0, 99) < 30);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 20, smem,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
           $urandom, $urandom_range(0, 99) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
